// File: rtl/wam_scan_dis.sv
// wam_scan_dis: score-to-BCD converter (sequential double dabble) and
// NDIG-digit common-anode multiplexer with leading-zero blanking, score
// saturation, optional difficulty digit, pause blink and last-hit dot.
module wam_scan_dis #(
  parameter int unsigned NDIG        = 4,
  parameter int unsigned SCORE_W     = 12,
  parameter int unsigned HRD_DIGIT   = 1,
  parameter int unsigned REFRESH_DIV = 16,
  parameter int unsigned BLINK_DIV   = 24
) (
  input  logic               i_clk,
  input  logic               i_clr_n,
  input  logic [SCORE_W-1:0] i_score,
  input  logic               i_score_vld,
  input  logic [1:0]         i_hrdn,
  input  logic               i_pause,
  input  logic               i_lstn,
  output logic               o_busy,
  output logic [NDIG-1:0]    o_an,
  output logic [6:0]         o_a2g,
  output logic               o_dp
);

  localparam int unsigned NSD = NDIG - HRD_DIGIT;
  localparam int unsigned BW  = 4 * NSD;
  localparam int unsigned IW  = $clog2(NDIG);
  localparam int unsigned CW  = $clog2(SCORE_W + 1);

  function automatic logic [31:0] pow10_m1(input int unsigned n);
    logic [31:0] v;
    v = 32'd1;
    for (int unsigned i = 0; i < n; i++) v = v * 32'd10;
    return v - 32'd1;
  endfunction

  localparam logic [31:0] MAXV = pow10_m1(NSD);

  // Clamp to the largest value the score digits can show.
  function automatic logic [SCORE_W-1:0] sat(input logic [SCORE_W-1:0] s);
    if (32'(s) > MAXV) return SCORE_W'(MAXV);
    return s;
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    unique case (d)
      4'd0:    g = 7'b1000000;
      4'd1:    g = 7'b1111001;
      4'd2:    g = 7'b0100100;
      4'd3:    g = 7'b0110000;
      4'd4:    g = 7'b0011001;
      4'd5:    g = 7'b0010010;
      4'd6:    g = 7'b0000010;
      4'd7:    g = 7'b1111000;
      4'd8:    g = 7'b0000000;
      4'd9:    g = 7'b0010000;
      default: g = 7'h7F;
    endcase
    return g;
  endfunction

  typedef enum logic {StIdle, StShift} state_e;

  state_e             r_state, w_state_d;
  logic [SCORE_W-1:0] r_shf, w_shf_d;
  logic [BW-1:0]      r_bcd, w_bcd_d;
  logic [CW-1:0]      r_cnt, w_cnt_d;
  logic [BW-1:0]      r_disp, w_disp_d;
  logic [SCORE_W-1:0] r_pend, w_pend_d;
  logic               r_pend_vld, w_pend_vld_d;
  logic [BW-1:0]      w_adj, w_bcd_sh;

  logic [REFRESH_DIV-1:0] r_ref;
  logic [BLINK_DIV-1:0]   r_blk;
  logic [IW-1:0]          r_idx;
  logic                   r_run;
  logic                   w_wrap;

  logic [3:0]      w_nib;
  logic            w_upz;
  logic [6:0]      w_seg;
  logic [NDIG-1:0] w_an;
  logic            w_dp;
  logic            w_blank;

  assign o_busy = (r_state == StShift);

  // Double-dabble step: add 3 to nibbles >= 5, then shift in the next score bit.
  always_comb begin
    w_adj = r_bcd;
    for (int unsigned k = 0; k < NSD; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5) w_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
    end
    w_bcd_sh = BW'({w_adj, r_shf[SCORE_W-1]});
  end

  // Converter next state, pending slot and display register update.
  always_comb begin
    w_state_d    = r_state;
    w_shf_d      = r_shf;
    w_bcd_d      = r_bcd;
    w_cnt_d      = r_cnt;
    w_disp_d     = r_disp;
    w_pend_d     = r_pend;
    w_pend_vld_d = r_pend_vld;
    unique case (r_state)
      StIdle: begin
        if (i_score_vld) begin
          w_state_d = StShift;
          w_shf_d   = sat(i_score);
          w_bcd_d   = '0;
          w_cnt_d   = CW'(SCORE_W);
        end
      end
      StShift: begin
        w_shf_d = {r_shf[SCORE_W-2:0], 1'b0};
        w_bcd_d = w_bcd_sh;
        w_cnt_d = r_cnt - CW'(1);
        if (i_score_vld) begin
          w_pend_d     = i_score;
          w_pend_vld_d = 1'b1;
        end
        if (r_cnt == CW'(1)) begin
          w_disp_d = w_bcd_sh;
          // A request seen this cycle is newer than anything already pending.
          if (i_score_vld || r_pend_vld) begin
            w_shf_d      = sat(i_score_vld ? i_score : r_pend);
            w_bcd_d      = '0;
            w_cnt_d      = CW'(SCORE_W);
            w_pend_vld_d = 1'b0;
          end else begin
            w_state_d = StIdle;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Converter state registers.
  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      r_state    <= StIdle;
      r_shf      <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_disp     <= '0;
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_shf      <= w_shf_d;
      r_bcd      <= w_bcd_d;
      r_cnt      <= w_cnt_d;
      r_disp     <= w_disp_d;
      r_pend     <= w_pend_d;
      r_pend_vld <= w_pend_vld_d;
    end
  end

  assign w_wrap = &r_ref;

  // Free-running refresh/blink counters; digit index steps on refresh wrap.
  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      r_ref <= '0;
      r_blk <= '0;
      r_idx <= '0;
      r_run <= 1'b0;
    end else begin
      r_ref <= r_ref + REFRESH_DIV'(1);
      r_blk <= r_blk + BLINK_DIV'(1);
      if (w_wrap) begin
        r_run <= 1'b1;
        r_idx <= (r_idx == IW'(NDIG - 1)) ? '0 : r_idx + IW'(1);
      end
    end
  end

  // Digit content for the current index.
  always_comb begin
    w_nib = 4'd0;
    w_upz = 1'b1;
    for (int unsigned k = 0; k < NSD; k++) begin
      if (32'(r_idx) == k) w_nib = r_disp[4*k +: 4];
      if (k >= 32'(r_idx) && r_disp[4*k +: 4] != 4'd0) w_upz = 1'b0;
    end
    if (HRD_DIGIT == 1 && r_idx == IW'(NDIG - 1)) begin
      w_seg = (i_hrdn == 2'd3) ? 7'b0111111 : glyph({2'b00, i_hrdn} + 4'd1);
    end else if (r_idx != '0 && w_upz) begin
      w_seg = 7'h7F;
    end else begin
      w_seg = glyph(w_nib);
    end
    w_an    = ~(NDIG'(1) << r_idx);
    w_dp    = ~((r_idx == '0) && i_lstn);
    w_blank = i_pause && r_blk[BLINK_DIV-1];
  end

  // Registered pin drivers; dark until the first refresh wrap or while blinking off.
  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      o_an  <= '1;
      o_a2g <= 7'h7F;
      o_dp  <= 1'b1;
    end else if (!r_run || w_blank) begin
      o_an  <= '1;
      o_a2g <= 7'h7F;
      o_dp  <= 1'b1;
    end else begin
      o_an  <= w_an;
      o_a2g <= w_seg;
      o_dp  <= w_dp;
    end
  end

endmodule

// File: tb/tb_wam_scan_dis.sv
// Self-checking bench for wam_scan_dis: integer-level display model plus
// directed literal checks and a randomized phase.
module tb_wam_scan_dis;

  localparam int unsigned NDIG = 4;
  localparam int unsigned SW   = 12;
  localparam int unsigned HRD  = 1;
  localparam int unsigned RD   = 2;
  localparam int unsigned BD   = 4;
  localparam int          MAXV = 999;

  logic          clk   = 1'b0;
  logic          clr_n = 1'b0;
  logic [SW-1:0] score = '0;
  logic          vld   = 1'b0;
  logic [1:0]    hrdn  = 2'd0;
  logic          pause = 1'b0;
  logic          lstn  = 1'b0;
  logic            busy;
  logic [NDIG-1:0] an;
  logic [6:0]      a2g;
  logic            dp;

  int n_tot  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  wam_scan_dis #(
    .NDIG(NDIG), .SCORE_W(SW), .HRD_DIGIT(HRD), .REFRESH_DIV(RD), .BLINK_DIV(BD)
  ) dut (
    .i_clk(clk), .i_clr_n(clr_n), .i_score(score), .i_score_vld(vld), .i_hrdn(hrdn),
    .i_pause(pause), .i_lstn(lstn), .o_busy(busy), .o_an(an), .o_a2g(a2g), .o_dp(dp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic int pow10(input int n);
    int v = 1;
    for (int i = 0; i < n; i++) v = v * 10;
    return v;
  endfunction

  // {an, a2g, dp} expected after an edge, given the count of edges since reset
  // before that edge and the value on display.
  function automatic logic [NDIG+7:0] exp_out(input int cyc, input int disp,
                                              input logic [1:0] h, input logic l,
                                              input logic p);
    int idx;
    logic [6:0] seg;
    logic [NDIG-1:0] a;
    logic d;
    if (cyc < (1 << RD) || (p && (((cyc >> (BD - 1)) & 1) == 1)))
      return {{NDIG{1'b1}}, 7'h7F, 1'b1};
    idx = (cyc >> RD) % NDIG;
    a   = ~(NDIG'(1) << idx);
    d   = !(idx == 0 && l);
    if (HRD == 1 && idx == NDIG - 1) seg = (h == 2'd3) ? 7'b0111111 : glyph(int'(h) + 1);
    else if (idx > 0 && disp < pow10(idx)) seg = 7'h7F;
    else seg = glyph((disp / pow10(idx)) % 10);
    return {a, seg, d};
  endfunction

  // Behavioural model: a conversion shows min(score, MAXV) SW cycles after it starts.
  int m_cyc = 0, m_disp = 0, m_left = 0, m_val = 0, m_pend = 0;
  bit m_busy = 1'b0, m_pv = 1'b0;
  logic [NDIG+7:0] e_out = {{NDIG{1'b1}}, 7'h7F, 1'b1};

  function automatic int satv(input logic [SW-1:0] s);
    return (int'(s) > MAXV) ? MAXV : int'(s);
  endfunction

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      m_cyc  <= 0;
      m_disp <= 0;
      m_busy <= 1'b0;
      m_pv   <= 1'b0;
      e_out  <= {{NDIG{1'b1}}, 7'h7F, 1'b1};
    end else begin
      e_out <= exp_out(m_cyc, m_disp, hrdn, lstn, pause);
      m_cyc <= m_cyc + 1;
      if (!m_busy) begin
        if (vld) begin
          m_busy <= 1'b1;
          m_left <= SW;
          m_val  <= satv(score);
        end
      end else if (m_left == 1) begin
        m_disp <= m_val;
        if (vld || m_pv) begin
          m_left <= SW;
          m_val  <= satv(vld ? score : SW'(m_pend));
          m_pv   <= 1'b0;
        end else begin
          m_busy <= 1'b0;
        end
      end else begin
        m_left <= m_left - 1;
        if (vld) begin
          m_pv   <= 1'b1;
          m_pend <= int'(score);
        end
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("an", 32'(an), 32'(e_out[NDIG+7:8]));
      chk("a2g", 32'(a2g), 32'(e_out[7:1]));
      chk("dp", 32'(dp), 32'(e_out[0]));
      chk("busy", 32'(busy), 32'(m_busy));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_an(input logic [NDIG-1:0] t, input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (an === t) ok = 1'b1;
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  // Requests a at cycle 0, b at cycle 3, c at cycle 6 (negative = none);
  // returns how many cycles busy was high over the window.
  task automatic conv(input int a, input int b, input int c, output int nb);
    nb = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      vld = 1'b0;
      if (i == 0) begin vld = 1'b1; score = SW'(a); end
      if (i == 3 && b >= 0) begin vld = 1'b1; score = SW'(b); end
      if (i == 6 && c >= 0) begin vld = 1'b1; score = SW'(c); end
      @(negedge clk);
      if (busy === 1'b1) nb++;
    end
  endtask

  initial begin
    int nb;
    repeat (2) @(posedge clk);
    #2 chk_en = 1'b1;
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_a2g", 32'(a2g), 32'h7F);
    chk("rst_busy", 32'(busy), 32'd0);
    step();
    clr_n = 1'b1;
    // Idle display after reset: "0" with leading blanks, easy level on the left.
    wait_an(4'b1110, "w_rst0");
    chk("rst_d0", 32'(a2g), 32'(7'b1000000));
    wait_an(4'b1101, "w_rst1");
    chk("rst_d1", 32'(a2g), 32'h7F);
    wait_an(4'b1011, "w_rst2");
    chk("rst_d2", 32'(a2g), 32'h7F);
    wait_an(4'b0111, "w_rst3");
    chk("rst_d3", 32'(a2g), 32'(7'b1111001));

    // 123 at hard level.
    step();
    hrdn = 2'd2;
    conv(123, -1, -1, nb);
    chk("busy123", 32'(nb), 32'd12);
    wait_an(4'b1110, "w123_0");
    chk("s123_d0", 32'(a2g), 32'(7'b0110000));
    wait_an(4'b1101, "w123_1");
    chk("s123_d1", 32'(a2g), 32'(7'b0100100));
    wait_an(4'b1011, "w123_2");
    chk("s123_d2", 32'(a2g), 32'(7'b1111001));
    wait_an(4'b0111, "w123_3");
    chk("s123_d3", 32'(a2g), 32'(7'b0110000));

    // 7 with the last-hit dot.
    step();
    lstn = 1'b1;
    conv(7, -1, -1, nb);
    wait_an(4'b1110, "w7_0");
    chk("s7_d0", 32'(a2g), 32'(7'b1111000));
    chk("s7_dp0", 32'(dp), 32'd0);
    wait_an(4'b1101, "w7_1");
    chk("s7_d1", 32'(a2g), 32'h7F);
    chk("s7_dp1", 32'(dp), 32'd1);
    wait_an(4'b1011, "w7_2");
    chk("s7_d2", 32'(a2g), 32'h7F);

    // Saturation.
    step();
    lstn = 1'b0;
    conv(4095, -1, -1, nb);
    wait_an(4'b1110, "wsat0");
    chk("sat_d0", 32'(a2g), 32'(7'b0010000));
    wait_an(4'b1101, "wsat1");
    chk("sat_d1", 32'(a2g), 32'(7'b0010000));
    wait_an(4'b1011, "wsat2");
    chk("sat_d2", 32'(a2g), 32'(7'b0010000));

    // Back-to-back requests: newest pending wins, busy never drops.
    conv(45, 300, 678, nb);
    chk("busy_chain", 32'(nb), 32'd24);
    wait_an(4'b1110, "w678_0");
    chk("s678_d0", 32'(a2g), 32'(7'b0000000));
    wait_an(4'b1101, "w678_1");
    chk("s678_d1", 32'(a2g), 32'(7'b1111000));
    wait_an(4'b1011, "w678_2");
    chk("s678_d2", 32'(a2g), 32'(7'b0000010));

    // Blink: dark half of every blink period.
    step();
    pause = 1'b1;
    step();
    nb = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (an === 4'b1111) nb++;
    end
    chk("blink_dark", 32'(nb), 32'd8);
    step();
    pause = 1'b0;

    // Reset mid-conversion.
    vld   = 1'b1;
    score = SW'(555);
    step();
    vld = 1'b0;
    repeat (3) step();
    clr_n = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_an", 32'(an), 32'hF);
    repeat (3) step();
    clr_n = 1'b1;
    wait_an(4'b1110, "wrm0");
    chk("rst_mid_d0", 32'(a2g), 32'(7'b1000000));

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step();
      vld   = ($urandom_range(0, 7) == 0);
      score = SW'($urandom);
      hrdn  = 2'($urandom);
      lstn  = 1'($urandom);
      if ($urandom_range(0, 99) == 0) pause = ~pause;
      if (i == 1500) clr_n = 1'b0;
      if (i == 1503) clr_n = 1'b1;
    end
    step();
    vld = 1'b0;
    repeat (2) step();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
